// File: rtl/tmb_tx_pkg.sv
// Shared encodings for the TMB trigger-fiber TX path: link sequencer states and
// the 8b/10b comma words the datapath sends while held in TRG_RST.
package tmb_tx_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        COMMA     = 3'd1,
        ALIGN     = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } link_state_t;

    localparam logic [31:0] COMMA_WORD = 32'h50BC_50BC;
    localparam logic [15:0] FRAME_SEP  = 16'h50BC;
    localparam logic [15:0] LTNCY_SEP  = 16'h50FC;
    localparam logic [3:0]  COMMA_ISK  = 4'b0101;

endpackage

// File: rtl/tmb_tx_link_ctrl_if.sv
// Link-control bundle between the TX link sequencer (master) and the GTX/datapath side (slave).
// All signals are levels or single-cycle pulses in the TRG_CLK80 domain; there is no valid/ready pairing.
interface tmb_tx_link_ctrl_if;

    logic       TX_SYNC_DONE;
    logic       TRG_TX_PLL_LOCK;
    logic       TX_SEL;
    logic       REQ_TEST;
    logic       TRG_RST_OUT;
    logic       ENA_TEST_PAT;
    logic       LINK_UP;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;
    logic       SYNC_RETRY;

    modport master (
        input  TX_SYNC_DONE, TRG_TX_PLL_LOCK, TX_SEL, REQ_TEST,
        output TRG_RST_OUT, ENA_TEST_PAT, LINK_UP, STATE, LOCK_LOSS_CNT, SYNC_RETRY
    );

    modport slave (
        output TX_SYNC_DONE, TRG_TX_PLL_LOCK, TX_SEL, REQ_TEST,
        input  TRG_RST_OUT, ENA_TEST_PAT, LINK_UP, STATE, LOCK_LOSS_CNT, SYNC_RETRY
    );

endinterface

// File: rtl/tmb_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear to 0.
module tmb_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tmb_tx_link_ctrl.sv
// TX link startup/recovery sequencer: WAIT_SYNC -> COMMA -> ALIGN -> RUN, FAULT on PLL lock loss.
// Define TMB_TX_LINK_WDOG_EN to build the WAIT_SYNC watchdog (SYNC_RETRY); otherwise SYNC_RETRY is 0.
module tmb_tx_link_ctrl
    import tmb_tx_pkg::*;
#(
    parameter int COMMA_FRAMES = 16,
    parameter int LOCK_STABLE  = 256
`ifdef TMB_TX_LINK_WDOG_EN
    , parameter int WDOG_CYCLES = 65535
`endif
) (
    input  logic TRG_CLK80,
    input  logic TRG_TXRESETDONE,
    tmb_tx_link_ctrl_if.master lnk
);

    localparam logic [8:0]  COMMA_LAST = 9'(2 * COMMA_FRAMES - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_STABLE - 1);

    link_state_t state, state_nxt;
    logic [8:0]  cnt, cnt_nxt;
    logic [15:0] lock_cnt, lock_cnt_nxt;
    logic [7:0]  loss_cnt, loss_cnt_nxt;
    logic        mode, mode_nxt;
    logic        trg_rst_q, link_up_q;
    logic        pll_lock_s, req_test_s;
    logic        active;

    tmb_sync2 u_sync_lock (
        .clk   (TRG_CLK80),
        .rst_n (TRG_TXRESETDONE),
        .d     (lnk.TRG_TX_PLL_LOCK),
        .q     (pll_lock_s)
    );

    tmb_sync2 u_sync_req (
        .clk   (TRG_CLK80),
        .rst_n (TRG_TXRESETDONE),
        .d     (lnk.REQ_TEST),
        .q     (req_test_s)
    );

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            state     <= WAIT_SYNC;
            cnt       <= '0;
            lock_cnt  <= '0;
            loss_cnt  <= '0;
            mode      <= 1'b0;
            trg_rst_q <= 1'b1;
            link_up_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lock_cnt  <= lock_cnt_nxt;
            loss_cnt  <= loss_cnt_nxt;
            mode      <= mode_nxt;
            // Commas are released only in ALIGN/RUN, so TRG_RST only rises at a state change.
            trg_rst_q <= !(state_nxt == ALIGN || state_nxt == RUN);
            link_up_q <= (state == RUN) && (state_nxt == RUN) && (link_up_q || lnk.TX_SEL);
        end
    end

    assign active = (state == COMMA) || (state == ALIGN) || (state == RUN);

    // Priority: lock loss, then sync loss, then mode change, then per-state timeouts.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lock_cnt_nxt = '0;
        loss_cnt_nxt = loss_cnt;
        mode_nxt     = mode;
        if (active && !pll_lock_s) begin
            state_nxt = FAULT;
            cnt_nxt   = '0;
            if (loss_cnt != 8'hFF) loss_cnt_nxt = loss_cnt + 8'd1;
        end else if (active && !lnk.TX_SYNC_DONE) begin
            state_nxt = WAIT_SYNC;
            cnt_nxt   = '0;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (lnk.TX_SYNC_DONE && pll_lock_s) begin
                        state_nxt = COMMA;
                        cnt_nxt   = '0;
                    end
                end
                COMMA: begin
                    if (cnt == COMMA_LAST) begin
                        state_nxt = ALIGN;
                        cnt_nxt   = '0;
                        mode_nxt  = req_test_s;
                    end else begin
                        cnt_nxt = cnt + 9'd1;
                    end
                end
                ALIGN: begin
                    if (cnt == 9'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 9'd1;
                    end
                end
                RUN: begin
                    // Restart through COMMA so the PRBS generator reseeds on a clean frame.
                    if (req_test_s != mode) begin
                        state_nxt = COMMA;
                        cnt_nxt   = '0;
                    end
                end
                FAULT: begin
                    if (pll_lock_s) begin
                        if (lock_cnt == LOCK_LAST) begin
                            state_nxt = WAIT_SYNC;
                        end else begin
                            lock_cnt_nxt = lock_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = WAIT_SYNC;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef TMB_TX_LINK_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt;
    logic        retry_q;

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            wdog_cnt <= '0;
            retry_q  <= 1'b0;
        end else if (state == WAIT_SYNC && state_nxt == WAIT_SYNC) begin
            if (wdog_cnt == WDOG_LAST) begin
                wdog_cnt <= '0;
                retry_q  <= 1'b1;
            end else begin
                wdog_cnt <= wdog_cnt + 16'd1;
                retry_q  <= 1'b0;
            end
        end else begin
            wdog_cnt <= '0;
            retry_q  <= 1'b0;
        end
    end

    assign lnk.SYNC_RETRY = retry_q;
`else
    assign lnk.SYNC_RETRY = 1'b0;
`endif

    assign lnk.TRG_RST_OUT   = trg_rst_q;
    assign lnk.ENA_TEST_PAT  = mode;
    assign lnk.LINK_UP       = link_up_q;
    assign lnk.STATE         = state;
    assign lnk.LOCK_LOSS_CNT = loss_cnt;

endmodule

// File: tb/tb_tmb_tx_link_ctrl.sv
// Directed bench for tmb_tx_link_ctrl: startup, mode change, lock loss/recovery,
// loss-count saturation (second fast instance), async reset and the optional watchdog.
`timescale 1ns/1ps
module tb_tmb_tx_link_ctrl;
  import tmb_tx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  tmb_tx_link_ctrl_if lnk ();
  tmb_tx_link_ctrl_if sat ();

  tmb_tx_link_ctrl #(
    .COMMA_FRAMES (16),
    .LOCK_STABLE  (256)
`ifdef TMB_TX_LINK_WDOG_EN
    , .WDOG_CYCLES (100)
`endif
  ) dut (
    .TRG_CLK80       (clk),
    .TRG_TXRESETDONE (rst_n),
    .lnk             (lnk)
  );

  tmb_tx_link_ctrl #(
    .COMMA_FRAMES (1),
    .LOCK_STABLE  (2)
  ) u_sat (
    .TRG_CLK80       (clk),
    .TRG_TXRESETDONE (rst_n),
    .lnk             (sat)
  );

  // clock
  always #5 clk = ~clk;

  // frame phase toggles every clk
  initial begin
    lnk.TX_SEL = 1'b0;
    forever begin
      @(posedge clk);
      #2 lnk.TX_SEL = ~lnk.TX_SEL;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_main(input logic [2:0] st, input int max, input string tag);
    int k = 0;
    while (lnk.STATE !== st && k < max) begin
      tick();
      k++;
    end
    check_eq(tag, {29'd0, lnk.STATE}, {29'd0, st});
  endtask

  task automatic wait_sat(input logic [2:0] st, input int max, input string tag);
    int k = 0;
    while (sat.STATE !== st && k < max) begin
      tick();
      k++;
    end
    check_eq(tag, {29'd0, sat.STATE}, {29'd0, st});
  endtask

  task automatic wait_sat_active(input int max, input string tag);
    int k = 0;
    logic act;
    act = (sat.STATE == COMMA) || (sat.STATE == ALIGN) || (sat.STATE == RUN);
    while (!act && k < max) begin
      tick();
      k++;
      act = (sat.STATE == COMMA) || (sat.STATE == ALIGN) || (sat.STATE == RUN);
    end
    check_eq(tag, {31'd0, act}, 32'd1);
  endtask

  // COMMA (32 clk, TRG_RST high) -> ALIGN (2 clk) -> RUN, then LINK_UP on frame start
  task automatic run_seq(input logic exp_mode, input string tag);
    int n;
    logic rst_ok;
    wait_main(COMMA, 10, {tag, "_enter_comma"});
    check_eq({tag, "_linkup_comma"}, {31'd0, lnk.LINK_UP}, 32'd0);
    n = 0;
    rst_ok = 1'b1;
    while (lnk.STATE == COMMA && n < 100) begin
      if (lnk.TRG_RST_OUT !== 1'b1) rst_ok = 1'b0;
      tick();
      n++;
    end
    check_eq({tag, "_comma_len"}, n, 32'd32);
    check_eq({tag, "_comma_rst"}, {31'd0, rst_ok}, 32'd1);
    check_eq({tag, "_align_state"}, {29'd0, lnk.STATE}, {29'd0, ALIGN});
    check_eq({tag, "_align_rst"}, {31'd0, lnk.TRG_RST_OUT}, 32'd0);
    check_eq({tag, "_align_ena"}, {31'd0, lnk.ENA_TEST_PAT}, {31'd0, exp_mode});
    n = 0;
    while (lnk.STATE == ALIGN && n < 10) begin
      tick();
      n++;
    end
    check_eq({tag, "_align_len"}, n, 32'd2);
    check_eq({tag, "_run_state"}, {29'd0, lnk.STATE}, {29'd0, RUN});
    check_eq({tag, "_linkup_first_run"}, {31'd0, lnk.LINK_UP}, 32'd0);
    n = 0;
    while (lnk.LINK_UP !== 1'b1 && n < 3) begin
      tick();
      n++;
    end
    check_eq({tag, "_linkup"}, {31'd0, lnk.LINK_UP}, 32'd1);
    check_eq({tag, "_run_ena"}, {31'd0, lnk.ENA_TEST_PAT}, {31'd0, exp_mode});
    check_eq({tag, "_run_rst"}, {31'd0, lnk.TRG_RST_OUT}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, {29'd0, lnk.STATE}, 32'd0);
    check_eq({tag, "_rst_out"}, {31'd0, lnk.TRG_RST_OUT}, 32'd1);
    check_eq({tag, "_ena"}, {31'd0, lnk.ENA_TEST_PAT}, 32'd0);
    check_eq({tag, "_linkup"}, {31'd0, lnk.LINK_UP}, 32'd0);
    check_eq({tag, "_loss"}, {24'd0, lnk.LOCK_LOSS_CNT}, 32'd0);
    check_eq({tag, "_retry"}, {31'd0, lnk.SYNC_RETRY}, 32'd0);
  endtask

  initial begin
    int pulses;
    lnk.TX_SYNC_DONE    = 1'b1;
    lnk.TRG_TX_PLL_LOCK = 1'b1;
    lnk.REQ_TEST        = 1'b0;
    sat.TX_SYNC_DONE    = 1'b1;
    sat.TRG_TX_PLL_LOCK = 1'b1;
    sat.TX_SEL          = 1'b1;
    sat.REQ_TEST        = 1'b0;

    // 1: reset values, then startup into RUN with comparator data
    tick(3);
    check_reset_vals("t1_reset");
    rst_n = 1'b1;
    run_seq(1'b0, "t1");

    // 2: PRBS request and back
    tick(4);
    lnk.REQ_TEST = 1'b1;
    run_seq(1'b1, "t2_prbs");
    tick(4);
    lnk.REQ_TEST = 1'b0;
    run_seq(1'b0, "t2_data");

    // TX_SYNC_DONE loss in RUN: straight to WAIT_SYNC, no lock-loss count
    tick(3);
    lnk.TX_SYNC_DONE = 1'b0;
    tick();
    check_eq("sync_drop_state", {29'd0, lnk.STATE}, {29'd0, WAIT_SYNC});
    check_eq("sync_drop_loss", {24'd0, lnk.LOCK_LOSS_CNT}, 32'd0);
    check_eq("sync_drop_rst", {31'd0, lnk.TRG_RST_OUT}, 32'd1);
    check_eq("sync_drop_linkup", {31'd0, lnk.LINK_UP}, 32'd0);
    lnk.TX_SYNC_DONE = 1'b1;
    run_seq(1'b0, "sync_recover");

    // 3: one-clk lock drop in RUN, glitch in FAULT restarts stable count
    tick(3);
    lnk.TRG_TX_PLL_LOCK = 1'b0;
    tick();
    lnk.TRG_TX_PLL_LOCK = 1'b1;
    wait_main(FAULT, 6, "t3_fault");
    check_eq("t3_loss1", {24'd0, lnk.LOCK_LOSS_CNT}, 32'd1);
    check_eq("t3_rst", {31'd0, lnk.TRG_RST_OUT}, 32'd1);
    check_eq("t3_linkup", {31'd0, lnk.LINK_UP}, 32'd0);
    tick(100);
    lnk.TRG_TX_PLL_LOCK = 1'b0;
    tick();
    lnk.TRG_TX_PLL_LOCK = 1'b1;
    tick(257);
    check_eq("t3_still_fault", {29'd0, lnk.STATE}, {29'd0, FAULT});
    tick();
    check_eq("t3_wait_sync", {29'd0, lnk.STATE}, {29'd0, WAIT_SYNC});
    check_eq("t3_loss_no_inc", {24'd0, lnk.LOCK_LOSS_CNT}, 32'd1);
    run_seq(1'b0, "t3_recover");

    // 5: async reset mid-RUN (PRBS mode) and mid-COMMA
    lnk.REQ_TEST = 1'b1;
    run_seq(1'b1, "t5_prbs");
    tick(5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_run_rst");
    lnk.REQ_TEST = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wait_main(COMMA, 10, "t5_comma");
    tick(10);
    rst_n = 1'b0;
    #1;
    check_eq("t5_comma_rst_state", {29'd0, lnk.STATE}, 32'd0);
    check_eq("t5_comma_rst_out", {31'd0, lnk.TRG_RST_OUT}, 32'd1);
    tick();
    rst_n = 1'b1;

    // 4: lock-loss counter saturation on the fast instance
    for (int i = 0; i < 300; i++) begin
      wait_sat_active(20, "t4_active");
      sat.TRG_TX_PLL_LOCK = 1'b0;
      tick();
      sat.TRG_TX_PLL_LOCK = 1'b1;
      wait_sat(FAULT, 10, "t4_fault");
      if (i == 0)   check_eq("t4_loss_1", {24'd0, sat.LOCK_LOSS_CNT}, 32'd1);
      if (i == 253) check_eq("t4_loss_254", {24'd0, sat.LOCK_LOSS_CNT}, 32'hFE);
      if (i == 254) check_eq("t4_loss_255", {24'd0, sat.LOCK_LOSS_CNT}, 32'hFF);
    end
    check_eq("t4_loss_sat", {24'd0, sat.LOCK_LOSS_CNT}, 32'hFF);

    // 6: hold TX_SYNC_DONE low in WAIT_SYNC and count retry pulses
    lnk.TX_SYNC_DONE = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (lnk.SYNC_RETRY === 1'b1) pulses++;
    end
`ifdef TMB_TX_LINK_WDOG_EN
    check_eq("t6_retry_pulses", pulses, 32'd2);
`else
    check_eq("t6_retry_pulses", pulses, 32'd0);
`endif
    check_eq("t6_state", {29'd0, lnk.STATE}, {29'd0, WAIT_SYNC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
